// File: rtl/freq_count_ctrl.sv
// freq_count_ctrl: gate/measurement controller for the two-digit frequency counter.
// Counts rising edges of an async input over a fixed gate window, converts the
// count to BCD by repeated subtraction, then strobes load for one cycle.
//
// Parameters
//   UPDATE_PERIOD  gate window length in clk cycles (16 .. 2^20)
// Ports
//   clk         in   system clock, all logic on posedge
//   reset       in   synchronous, active-high reset
//   signal      in   asynchronous input whose rising edges are counted
//   gate        out  high while counting (edges accepted)
//   ten_count   out  BCD tens digit, registered
//   unit_count  out  BCD units digit, registered
//   load        out  one-cycle strobe, digits are new and valid
//   overflow    out  only when FREQ_CTRL_OVF_EN is defined
// Configuration
//   FREQ_CTRL_OVF_EN  defined: edge count saturates at 99 and the overflow port
//                     reports a rise seen at 99 during the window.
//                     undefined: edge count wraps 99 -> 0 (display = edges mod 100).
module freq_count_ctrl #(
    parameter int UPDATE_PERIOD = 1200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       signal,
    output logic       gate,
    output logic [3:0] ten_count,
    output logic [3:0] unit_count,
    output logic       load
`ifdef FREQ_CTRL_OVF_EN
    ,
    output logic       overflow
`endif
);

    localparam int WW = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;
    localparam logic [WW-1:0] WIN_LAST = WW'(UPDATE_PERIOD - 1);

    typedef enum logic [1:0] {
        S_COUNT,
        S_CONVERT,
        S_LOAD
    } state_t;

    state_t state;
    state_t state_next;

    logic [WW-1:0] window_cnt;
    logic [6:0]    edge_cnt;
    logic [6:0]    edge_next;
    logic [6:0]    work;
    logic [3:0]    tens;
    logic          sync1;
    logic          sync2;
    logic          prev;
    logic          rise;
    logic          win_last;
    logic          edge_at_max;
    logic          work_ge10;

    assign rise        = sync2 & ~prev;
    assign win_last    = (window_cnt == WIN_LAST);
    assign edge_at_max = (edge_cnt == 7'd99);
    assign work_ge10   = (work >= 7'd10);

    // Count including a rise detected this cycle, so the last window cycle's
    // rise reaches the conversion.
    always_comb begin
        edge_next = edge_cnt;
        if (rise) begin
            if (edge_at_max) begin
`ifdef FREQ_CTRL_OVF_EN
                edge_next = 7'd99;
`else
                edge_next = 7'd0;
`endif
            end else begin
                edge_next = edge_cnt + 7'd1;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_COUNT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            S_COUNT:   if (win_last) state_next = S_CONVERT;
            S_CONVERT: if (!work_ge10) state_next = S_LOAD;
            S_LOAD:    state_next = S_COUNT;
            default:   state_next = S_COUNT;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        gate = (state == S_COUNT);
        load = (state == S_LOAD);
    end

    // Two-flop synchroniser plus a history flop for rise detection
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= signal;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Window, edge counting and BCD conversion datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            window_cnt <= '0;
            edge_cnt   <= 7'd0;
            work       <= 7'd0;
            tens       <= 4'd0;
            ten_count  <= 4'd0;
            unit_count <= 4'd0;
        end else begin
            unique case (state)
                S_COUNT: begin
                    edge_cnt <= edge_next;
                    if (win_last) begin
                        work <= edge_next;
                        tens <= 4'd0;
                    end else begin
                        window_cnt <= window_cnt + WW'(1);
                    end
                end
                S_CONVERT: begin
                    if (work_ge10) begin
                        work <= work - 7'd10;
                        tens <= tens + 4'd1;
                    end else begin
                        ten_count  <= tens;
                        unit_count <= work[3:0];
                    end
                end
                S_LOAD: begin
                    edge_cnt   <= 7'd0;
                    window_cnt <= '0;
                end
                default: begin
                    edge_cnt   <= 7'd0;
                    window_cnt <= '0;
                end
            endcase
        end
    end

`ifdef FREQ_CTRL_OVF_EN
    logic ovf_seen;
    logic ovf_work;

    // ovf_work snapshots the window's flag (including a last-cycle rise) so the
    // flag itself can be cleared independently of the conversion.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_seen <= 1'b0;
            ovf_work <= 1'b0;
            overflow <= 1'b0;
        end else begin
            unique case (state)
                S_COUNT: begin
                    if (rise && edge_at_max) ovf_seen <= 1'b1;
                    if (win_last) ovf_work <= ovf_seen | (rise & edge_at_max);
                end
                S_CONVERT: begin
                    if (!work_ge10) overflow <= ovf_work;
                end
                S_LOAD:  ovf_seen <= 1'b0;
                default: ovf_seen <= 1'b0;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_freq_count_ctrl.sv
// tb_freq_count_ctrl: table-driven check of freq_count_ctrl, plus hand-written
// sequences for load spacing, overflow/next window, mid-conversion reset, random windows.
module tb_freq_count_ctrl;

    localparam int PA = 100;
    localparam int PB = 240;

    logic       clk;
    logic       reset;
    logic       signal;
    logic       gate_a, gate_b;
    logic       load_a, load_b;
    logic [3:0] ten_a, ten_b;
    logic [3:0] unit_a, unit_b;
`ifdef FREQ_CTRL_OVF_EN
    logic       ovf_a, ovf_b;
`endif

    freq_count_ctrl #(.UPDATE_PERIOD(PA)) dut_a (
        .clk        (clk),
        .reset      (reset),
        .signal     (signal),
        .gate       (gate_a),
        .ten_count  (ten_a),
        .unit_count (unit_a),
        .load       (load_a)
`ifdef FREQ_CTRL_OVF_EN
        ,
        .overflow   (ovf_a)
`endif
    );

    freq_count_ctrl #(.UPDATE_PERIOD(PB)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .signal     (signal),
        .gate       (gate_b),
        .ten_count  (ten_b),
        .unit_count (unit_b),
        .load       (load_b)
`ifdef FREQ_CTRL_OVF_EN
        ,
        .overflow   (ovf_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bit         sel;
    logic       ld_s, gate_s;
    logic [3:0] ten_s, unit_s;
    assign ld_s   = sel ? load_b : load_a;
    assign gate_s = sel ? gate_b : gate_a;
    assign ten_s  = sel ? ten_b  : ten_a;
    assign unit_s = sel ? unit_b : unit_a;
`ifdef FREQ_CTRL_OVF_EN
    logic ovf_s;
    assign ovf_s = sel ? ovf_b : ovf_a;
`endif

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        bit big;
        int start;
        int n_win;
        int n_dead;
        int ten;
        int unit;
        bit ovf;
        int at;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Leaves time at posedge+1 of interval 0 (first window cycle).
    task automatic do_reset();
        reset  = 1'b1;
        signal = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Pulses one cycle high, one low; pulse i goes high in interval start+2i.
    task automatic drive(input int start, input int n);
        repeat (start) @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) begin
            signal = 1'b1;
            @(posedge clk);
            #1;
            signal = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    // Returns the interval index of the load pulse, -1 on timeout; stable=0 if
    // the digits moved while load was low.
    task automatic wait_load(input int maxc, output int at, output bit stable);
        logic [3:0] t0, u0;
        at = -1;
        stable = 1'b1;
        t0 = '0;
        u0 = '0;
        for (int c = 0; c <= maxc; c++) begin
            @(negedge clk);
            if (c == 0) begin
                t0 = ten_s;
                u0 = unit_s;
            end
            if (ld_s) begin
                at = c;
                break;
            end
            if (ten_s !== t0 || unit_s !== u0) stable = 1'b0;
        end
    endtask

    initial begin
        int at;
        bit st;
        int n;
        int early;

        reset  = 1'b1;
        signal = 1'b0;
        sel    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gate", int'(gate_a), 1);
        chk("rst_load", int'(load_a), 0);
        chk("rst_ten", int'(ten_a), 0);
        chk("rst_unit", int'(unit_a), 0);
        chk("rst_load_b", int'(load_b), 0);
`ifdef FREQ_CTRL_OVF_EN
        chk("rst_ovf", int'(ovf_a), 0);
`endif

        vecs[0] = '{0, 2, 37, 0, 3, 7, 0, 104};
        vecs[1] = '{0, 0, 0, 0, 0, 0, 0, 101};
        vecs[2] = '{0, 83, 8, 1, 0, 8, 0, 101};
`ifdef FREQ_CTRL_OVF_EN
        vecs[3] = '{1, 2, 105, 0, 9, 9, 1, 250};
`else
        vecs[3] = '{1, 2, 105, 0, 0, 5, 0, 241};
`endif
        vecs[4] = '{1, 10, 49, 0, 4, 9, 0, 245};
        vecs[5] = '{0, 0, 49, 0, 4, 9, 0, 105};
        vecs[6] = '{0, 20, 10, 0, 1, 0, 0, 102};
        vecs[7] = '{0, 88, 5, 1, 0, 5, 0, 101};

        for (int v = 0; v < 8; v++) begin
            sel = vecs[v].big;
            do_reset();
            fork
                drive(vecs[v].start, vecs[v].n_win + vecs[v].n_dead);
                wait_load(400, at, st);
            join
            chk($sformatf("v%0d_at", v), at, vecs[v].at);
            chk($sformatf("v%0d_ten", v), int'(ten_s), vecs[v].ten);
            chk($sformatf("v%0d_unit", v), int'(unit_s), vecs[v].unit);
            chk($sformatf("v%0d_gate", v), int'(gate_s), 0);
            chk($sformatf("v%0d_stable", v), int'(st), 1);
`ifdef FREQ_CTRL_OVF_EN
            chk($sformatf("v%0d_ovf", v), int'(ovf_s), int'(vecs[v].ovf));
`endif
            @(negedge clk);
            chk($sformatf("v%0d_load_width", v), int'(ld_s), 0);
        end

        // Empty windows: load every PA+2 cycles
        sel = 1'b0;
        do_reset();
        wait_load(400, at, st);
        chk("empty_first_at", at, PA + 1);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            wait_load(400, at, st);
            chk($sformatf("empty_spacing%0d", k), at + 1, PA + 2);
            chk($sformatf("empty_digits%0d", k), int'({ten_s, unit_s}), 0);
        end

        // Overflow window followed by a 12-rise window
        sel = 1'b1;
        do_reset();
        fork
            drive(2, 105);
            wait_load(400, at, st);
        join
        @(posedge clk);
        #1;
        fork
            drive(2, 12);
            wait_load(400, at, st);
        join
        chk("ovf_next_at", at, PB + 2);
        chk("ovf_next_ten", int'(ten_s), 1);
        chk("ovf_next_unit", int'(unit_s), 2);
        chk("ovf_next_stable", int'(st), 1);
`ifdef FREQ_CTRL_OVF_EN
        chk("ovf_next_ovf", int'(ovf_s), 0);
`endif

        // Reset during conversion of a 57 count
        do_reset();
        fork
            drive(2, 57);
            wait_load(400, at, st);
        join
        chk("rc_first_at", at, PB + 6);
        chk("rc_first_digits", int'({ten_s, unit_s}), 8'h57);
        @(posedge clk);
        #1;
        early = 0;
        fork
            drive(2, 57);
            for (int c = 0; c < 243; c++) begin
                @(negedge clk);
                if (load_b) early++;
                @(posedge clk);
                #1;
            end
        join
        chk("rc_no_early_load", early, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("rc_convert_no_load", int'(load_b), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rc_rst_load", int'(load_b), 0);
        chk("rc_rst_digits", int'({ten_b, unit_b}), 0);
        chk("rc_rst_gate", int'(gate_b), 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_load(400, at, st);
        chk("rc_new_window_at", at, PB + 1);
        chk("rc_new_digits", int'({ten_s, unit_s}), 0);

        // Random back-to-back windows
        do_reset();
        for (int w = 0; w < 20; w++) begin
            n = int'($urandom_range(0, 99));
            fork
                drive(2, n);
                wait_load(400, at, st);
            join
            chk($sformatf("rnd%0d_at", w), at, PB + n / 10 + 1);
            chk($sformatf("rnd%0d_ten", w), int'(ten_s), n / 10);
            chk($sformatf("rnd%0d_unit", w), int'(unit_s), n % 10);
            chk($sformatf("rnd%0d_stable", w), int'(st), 1);
`ifdef FREQ_CTRL_OVF_EN
            chk($sformatf("rnd%0d_ovf", w), int'(ovf_s), 0);
`endif
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
